// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg
// Shared definitions for the hardwired control unit:
//   - opcode constants (IR[31:27])
//   - ALU operation codes driven on the datapath 'control' bus
//   - step-sequencer state encoding
//   - MDR source select encodings
//   - the packed strobe bundle passed from the step decoder to the top
package cpu_ctrl_pkg;

    localparam int OP_W  = 5;
    localparam int ALU_W = 4;

    // Opcodes
    localparam logic [OP_W-1:0] OP_LD   = 5'd0;
    localparam logic [OP_W-1:0] OP_LDI  = 5'd1;
    localparam logic [OP_W-1:0] OP_ST   = 5'd2;
    localparam logic [OP_W-1:0] OP_ADD  = 5'd3;
    localparam logic [OP_W-1:0] OP_SUB  = 5'd4;
    localparam logic [OP_W-1:0] OP_AND  = 5'd5;
    localparam logic [OP_W-1:0] OP_OR   = 5'd6;
    localparam logic [OP_W-1:0] OP_SHR  = 5'd7;
    localparam logic [OP_W-1:0] OP_SHL  = 5'd8;
    localparam logic [OP_W-1:0] OP_ROR  = 5'd9;
    localparam logic [OP_W-1:0] OP_ROL  = 5'd10;
    localparam logic [OP_W-1:0] OP_ADDI = 5'd11;
    localparam logic [OP_W-1:0] OP_ANDI = 5'd12;
    localparam logic [OP_W-1:0] OP_ORI  = 5'd13;
    localparam logic [OP_W-1:0] OP_MUL  = 5'd14;
    localparam logic [OP_W-1:0] OP_DIV  = 5'd15;
    localparam logic [OP_W-1:0] OP_NEG  = 5'd16;
    localparam logic [OP_W-1:0] OP_NOT  = 5'd17;
    localparam logic [OP_W-1:0] OP_BR   = 5'd18;
    localparam logic [OP_W-1:0] OP_JR   = 5'd19;
    localparam logic [OP_W-1:0] OP_JAL  = 5'd20;
    localparam logic [OP_W-1:0] OP_IN   = 5'd21;
    localparam logic [OP_W-1:0] OP_OUT  = 5'd22;
    localparam logic [OP_W-1:0] OP_MFHI = 5'd23;
    localparam logic [OP_W-1:0] OP_MFLO = 5'd24;
    localparam logic [OP_W-1:0] OP_NOP  = 5'd25;
    localparam logic [OP_W-1:0] OP_HALT = 5'd26;

    // ALU operation codes (12..15 reserved)
    localparam logic [ALU_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_W-1:0] ALU_SHR = 4'd4;
    localparam logic [ALU_W-1:0] ALU_SHL = 4'd5;
    localparam logic [ALU_W-1:0] ALU_ROR = 4'd6;
    localparam logic [ALU_W-1:0] ALU_ROL = 4'd7;
    localparam logic [ALU_W-1:0] ALU_MUL = 4'd8;
    localparam logic [ALU_W-1:0] ALU_DIV = 4'd9;
    localparam logic [ALU_W-1:0] ALU_NEG = 4'd10;
    localparam logic [ALU_W-1:0] ALU_NOT = 4'd11;

    // MDR source select
    localparam logic [1:0] MDR_BUS = 2'b00;
    localparam logic [1:0] MDR_MEM = 2'b01;
    localparam logic [1:0] MDR_IMM = 2'b10;

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd9
    } ctrl_state_t;

    typedef struct packed {
        logic             pc_out;
        logic             pc_in;
        logic             inc_pc;
        logic             mar_in;
        logic             mdr_in;
        logic             mdr_out;
        logic             rd;
        logic             wr;
        logic             ir_in;
        logic             y_in;
        logic             zlo_in;
        logic             zhi_in;
        logic             zlo_out;
        logic             zhi_out;
        logic             hi_in;
        logic             hi_out;
        logic             lo_in;
        logic             lo_out;
        logic             inport_out;
        logic             outport_in;
        logic             c_out;
        logic             ba_out;
        logic             con_in;
        logic             r_in;
        logic             r_out;
        logic             gra;
        logic             grb;
        logic             grc;
        logic [1:0]       mdr_read;
        logic [ALU_W-1:0] control;
    } ctrl_strb_t;

    // ALU code used by the compute step of arithmetic/logic opcodes.
    function automatic logic [ALU_W-1:0] alu_code(input logic [OP_W-1:0] op);
        case (op)
            OP_SUB:          alu_code = ALU_SUB;
            OP_AND, OP_ANDI: alu_code = ALU_AND;
            OP_OR,  OP_ORI:  alu_code = ALU_OR;
            OP_SHR:          alu_code = ALU_SHR;
            OP_SHL:          alu_code = ALU_SHL;
            OP_ROR:          alu_code = ALU_ROR;
            OP_ROL:          alu_code = ALU_ROL;
            OP_MUL:          alu_code = ALU_MUL;
            OP_DIV:          alu_code = ALU_DIV;
            OP_NEG:          alu_code = ALU_NEG;
            OP_NOT:          alu_code = ALU_NOT;
            default:         alu_code = ALU_ADD;
        endcase
    endfunction

    // Opcodes 0..24 have execute steps; nop, halt and undefined codes end at T2.
    function automatic logic has_exec(input logic [OP_W-1:0] op);
        has_exec = (op <= OP_MFLO);
    endfunction

endpackage

// File: rtl/ctrl_step_decode.sv
// ctrl_step_decode
// Purely combinational Moore decode of the current step and opcode into the
// full datapath strobe bundle, plus a flag marking the opcode's final step.
//   state_i  : current sequencer state
//   opcode_i : IR[31:27]
//   con_ff_i : branch condition flag (only gates PCin in the branch T6 step)
//   strb_o   : strobe bundle; all-zero / ADD / MDR_BUS unless the step sets it
//   last_o   : 1 when this step completes the instruction
module ctrl_step_decode
    import cpu_ctrl_pkg::*;
(
    input  ctrl_state_t     state_i,
    input  logic [OP_W-1:0] opcode_i,
    input  logic            con_ff_i,
    output ctrl_strb_t      strb_o,
    output logic            last_o
);

    logic is_imm;
    assign is_imm = (opcode_i == OP_ADDI) || (opcode_i == OP_ANDI) || (opcode_i == OP_ORI);

    always_comb begin
        strb_o = '0;
        last_o = 1'b0;
        case (state_i)
            S_T0: begin
                strb_o.pc_out = 1'b1; strb_o.mar_in = 1'b1;
                strb_o.inc_pc = 1'b1; strb_o.zlo_in = 1'b1;
            end
            S_T1: begin
                strb_o.zlo_out = 1'b1; strb_o.pc_in  = 1'b1;
                strb_o.rd      = 1'b1; strb_o.mdr_in = 1'b1;
                strb_o.mdr_read = MDR_MEM;
            end
            S_T2: begin
                strb_o.mdr_out = 1'b1; strb_o.ir_in = 1'b1;
                last_o = !has_exec(opcode_i);
            end
            default: begin
                // Execute steps; RESET/HALT fall through every inner case untouched.
                case (opcode_i)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state_i)
                            S_T3: begin strb_o.grb = 1'b1; strb_o.r_out = 1'b1; strb_o.y_in = 1'b1; end
                            S_T4: begin
                                // Immediates take operand B from the C field instead of Rc.
                                if (is_imm) strb_o.c_out = 1'b1;
                                else begin strb_o.grc = 1'b1; strb_o.r_out = 1'b1; end
                                strb_o.zlo_in  = 1'b1;
                                strb_o.control = alu_code(opcode_i);
                            end
                            S_T5: begin
                                strb_o.zlo_out = 1'b1; strb_o.gra = 1'b1; strb_o.r_in = 1'b1;
                                last_o = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (state_i)
                            S_T3: begin
                                strb_o.grb = 1'b1; strb_o.r_out = 1'b1; strb_o.zlo_in = 1'b1;
                                strb_o.control = alu_code(opcode_i);
                            end
                            S_T4: begin
                                strb_o.zlo_out = 1'b1; strb_o.gra = 1'b1; strb_o.r_in = 1'b1;
                                last_o = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state_i)
                            S_T3: begin strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.y_in = 1'b1; end
                            S_T4: begin
                                strb_o.grb = 1'b1; strb_o.r_out = 1'b1;
                                strb_o.zlo_in = 1'b1; strb_o.zhi_in = 1'b1;
                                strb_o.control = alu_code(opcode_i);
                            end
                            S_T5: begin strb_o.zlo_out = 1'b1; strb_o.lo_in = 1'b1; end
                            S_T6: begin
                                strb_o.zhi_out = 1'b1; strb_o.hi_in = 1'b1;
                                last_o = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_LD, OP_LDI, OP_ST: begin
                        // Shared effective-address computation: Rb (or 0 via BAout) + C.
                        case (state_i)
                            S_T3: begin strb_o.grb = 1'b1; strb_o.ba_out = 1'b1; strb_o.y_in = 1'b1; end
                            S_T4: begin strb_o.c_out = 1'b1; strb_o.zlo_in = 1'b1; end
                            S_T5: begin
                                strb_o.zlo_out = 1'b1;
                                if (opcode_i == OP_LDI) begin
                                    strb_o.gra = 1'b1; strb_o.r_in = 1'b1;
                                    last_o = 1'b1;
                                end else begin
                                    strb_o.mar_in = 1'b1;
                                end
                            end
                            S_T6: begin
                                if (opcode_i == OP_LD) begin
                                    strb_o.rd = 1'b1; strb_o.mdr_in = 1'b1;
                                    strb_o.mdr_read = MDR_MEM;
                                end else if (opcode_i == OP_ST) begin
                                    strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.mdr_in = 1'b1;
                                    strb_o.mdr_read = MDR_BUS;
                                end
                            end
                            S_T7: begin
                                if (opcode_i == OP_LD) begin
                                    strb_o.mdr_out = 1'b1; strb_o.gra = 1'b1; strb_o.r_in = 1'b1;
                                    last_o = 1'b1;
                                end else if (opcode_i == OP_ST) begin
                                    strb_o.wr = 1'b1;
                                    last_o = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state_i)
                            S_T3: begin strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.con_in = 1'b1; end
                            S_T4: begin strb_o.pc_out = 1'b1; strb_o.y_in = 1'b1; end
                            S_T5: begin strb_o.c_out = 1'b1; strb_o.zlo_in = 1'b1; end
                            S_T6: begin
                                // Target is always computed; PC only takes it when taken.
                                strb_o.zlo_out = 1'b1;
                                strb_o.pc_in   = con_ff_i;
                                last_o = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_JR: begin
                        if (state_i == S_T3) begin
                            strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.pc_in = 1'b1;
                            last_o = 1'b1;
                        end
                    end
                    OP_JAL: begin
                        // Link register is selected through the Rb field (encodes R15).
                        case (state_i)
                            S_T3: begin strb_o.pc_out = 1'b1; strb_o.grb = 1'b1; strb_o.r_in = 1'b1; end
                            S_T4: begin
                                strb_o.gra = 1'b1; strb_o.r_out = 1'b1; strb_o.pc_in = 1'b1;
                                last_o = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_IN, OP_OUT, OP_MFHI, OP_MFLO: begin
                        if (state_i == S_T3) begin
                            strb_o.gra = 1'b1;
                            case (opcode_i)
                                OP_IN:   begin strb_o.inport_out = 1'b1; strb_o.r_in = 1'b1; end
                                OP_OUT:  begin strb_o.r_out = 1'b1; strb_o.outport_in = 1'b1; end
                                OP_MFHI: begin strb_o.hi_out = 1'b1; strb_o.r_in = 1'b1; end
                                default: begin strb_o.lo_out = 1'b1; strb_o.r_in = 1'b1; end
                            endcase
                            last_o = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// control_unit
// Hardwired Moore step sequencer for the single-bus datapath. Fetch runs
// T0..T2, execute runs T3..T7 depending on the opcode. The state advances on
// the falling edge of clk so every strobe is settled at the datapath's
// rising edge.
//   clk, reset  : falling-edge clock, synchronous active-high reset
//   stop        : halt at the next instruction boundary
//   IR          : instruction register; only IR[31:27] is decoded
//   CON_FF      : branch condition flag
//   strobes     : PC/MAR/MDR/IR/Y/Z/HI/LO/port/register-select enables
//   mdr_read    : MDR source select, control : ALU op code
//   run         : executing (not RESET/HALT), clear : in RESET
module control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int ALUW = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stop,
    input  logic [31:0]     IR,
    input  logic            CON_FF,
    output logic            PCout,
    output logic            PCin,
    output logic            IncPc,
    output logic            MARin,
    output logic            MDRin,
    output logic            MDRout,
    output logic            read,
    output logic            write,
    output logic            IRin,
    output logic            Yin,
    output logic            Zlowin,
    output logic            Zhighin,
    output logic            Zlowout,
    output logic            Zhighout,
    output logic            HIin,
    output logic            HIout,
    output logic            LOin,
    output logic            LOout,
    output logic            InPortout,
    output logic            OutPortin,
    output logic            Cout,
    output logic            BAout,
    output logic            CONin,
    output logic            Rin,
    output logic            Rout,
    output logic            GRA,
    output logic            GRB,
    output logic            GRC,
    output logic [1:0]      mdr_read,
    output logic [ALUW-1:0] control,
    output logic            run,
    output logic            clear
);

    ctrl_state_t     state_q, state_d;
    logic [OP_W-1:0] opcode;
    ctrl_strb_t      strb;
    logic            last;
    logic            unused_ir;

    assign opcode    = OP_W'(IR[31 -: OPW]);
    assign unused_ir = ^IR[31-OPW:0];

    ctrl_step_decode u_dec (
        .state_i  (state_q),
        .opcode_i (opcode),
        .con_ff_i (CON_FF),
        .strb_o   (strb),
        .last_o   (last)
    );

    always_ff @(negedge clk) begin
        if (reset) state_q <= S_RESET;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_T0;
            S_HALT:  state_d = S_HALT;
            S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7: begin
                // stop is only honoured at an instruction boundary.
                if (last)
                    state_d = (stop || (state_q == S_T2 && opcode == OP_HALT)) ? S_HALT : S_T0;
                else
                    state_d = ctrl_state_t'(state_q + 4'd1);
            end
            default: state_d = S_RESET;
        endcase
    end

    assign run   = (state_q != S_RESET) && (state_q != S_HALT);
    assign clear = (state_q == S_RESET);

    assign PCout     = strb.pc_out;
    assign PCin      = strb.pc_in;
    assign IncPc     = strb.inc_pc;
    assign MARin     = strb.mar_in;
    assign MDRin     = strb.mdr_in;
    assign MDRout    = strb.mdr_out;
    assign read      = strb.rd;
    assign write     = strb.wr;
    assign IRin      = strb.ir_in;
    assign Yin       = strb.y_in;
    assign Zlowin    = strb.zlo_in;
    assign Zhighin   = strb.zhi_in;
    assign Zlowout   = strb.zlo_out;
    assign Zhighout  = strb.zhi_out;
    assign HIin      = strb.hi_in;
    assign HIout     = strb.hi_out;
    assign LOin      = strb.lo_in;
    assign LOout     = strb.lo_out;
    assign InPortout = strb.inport_out;
    assign OutPortin = strb.outport_in;
    assign Cout      = strb.c_out;
    assign BAout     = strb.ba_out;
    assign CONin     = strb.con_in;
    assign Rin       = strb.r_in;
    assign Rout      = strb.r_out;
    assign GRA       = strb.gra;
    assign GRB       = strb.grb;
    assign GRC       = strb.grc;
    assign mdr_read  = strb.mdr_read;
    assign control   = ALUW'(strb.control);

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, stop, CON_FF;
    logic [31:0] IR;
    logic PCout, PCin, IncPc, MARin, MDRin, MDRout, read, write, IRin, Yin;
    logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, HIout, LOin, LOout;
    logic InPortout, OutPortin, Cout, BAout, CONin, Rin, Rout, GRA, GRB, GRC;
    logic [1:0] mdr_read;
    logic [3:0] control;
    logic run, clear;

    control_unit dut (
        .clk(clk), .reset(reset), .stop(stop), .IR(IR), .CON_FF(CON_FF),
        .PCout(PCout), .PCin(PCin), .IncPc(IncPc), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .read(read), .write(write), .IRin(IRin), .Yin(Yin),
        .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .InPortout(InPortout), .OutPortin(OutPortin), .Cout(Cout), .BAout(BAout),
        .CONin(CONin), .Rin(Rin), .Rout(Rout), .GRA(GRA), .GRB(GRB), .GRC(GRC),
        .mdr_read(mdr_read), .control(control), .run(run), .clear(clear)
    );

    // Observed vector layout (bit index = name below)
    localparam int PCOUT=0, PCIN=1, INCPC=2, MARIN=3, MDRIN=4, MDROUT=5, RD=6, WR=7;
    localparam int IRIN=8, YIN=9, ZLOIN=10, ZHIIN=11, ZLOOUT=12, ZHIOUT=13, HIIN=14, HIOUT=15;
    localparam int LOIN=16, LOOUT=17, INPOUT=18, OUTPIN=19, COUT=20, BAOUT=21, CONIN=22;
    localparam int RIN=23, ROUT=24, GA=25, GB=26, GC=27, RUN=34, CLR=35;
    // Model step encoding: 0..7 = T0..T7, 8 = RESET, 9 = HALT
    localparam int M_RST = 8, M_HALT = 9;

    logic [35:0] dutv;
    assign dutv = {clear, run, control, mdr_read, GRC, GRB, GRA, Rout, Rin, CONin, BAout,
                   Cout, OutPortin, InPortout, LOout, LOin, HIout, HIin, Zhighout, Zlowout,
                   Zhighin, Zlowin, Yin, IRin, write, read, MDRout, MDRin, MARin, IncPc,
                   PCin, PCout};

    int n_tests = 0, n_fail = 0;
    int ms = M_RST;
    int cur_op = 25;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Total cycles per instruction, fetch included.
    function automatic int ilen(int op);
        if (op inside {[3:13]})       return 6;
        if (op inside {14, 15})       return 7;
        if (op inside {16, 17})       return 5;
        if (op == 0 || op == 2)       return 8;
        if (op == 1)                  return 6;
        if (op == 18)                 return 7;
        if (op == 20)                 return 5;
        if (op == 19 || op inside {[21:24]}) return 4;
        return 3;
    endfunction

    function automatic int alu_of(int op);
        if (op <= 10) return op - 3;
        if (op == 11) return 0;
        if (op == 12) return 2;
        if (op == 13) return 3;
        return op - 6;
    endfunction

    function automatic logic [35:0] expv(int s, int op, bit con);
        logic [35:0] e;
        int ctl, mdr;
        e = '0; ctl = 0; mdr = 0;
        if (s == M_RST) begin e[CLR] = 1'b1; return e; end
        if (s == M_HALT) return e;
        e[RUN] = 1'b1;
        if (s == 0) begin e[PCOUT]=1; e[MARIN]=1; e[INCPC]=1; e[ZLOIN]=1; end
        else if (s == 1) begin e[ZLOOUT]=1; e[PCIN]=1; e[RD]=1; e[MDRIN]=1; mdr = 1; end
        else if (s == 2) begin e[MDROUT]=1; e[IRIN]=1; end
        else if (op inside {[3:13]}) begin
            if (s == 3) begin e[GB]=1; e[ROUT]=1; e[YIN]=1; end
            if (s == 4) begin
                if (op >= 11) e[COUT]=1; else begin e[GC]=1; e[ROUT]=1; end
                e[ZLOIN]=1; ctl = alu_of(op);
            end
            if (s == 5) begin e[ZLOOUT]=1; e[GA]=1; e[RIN]=1; end
        end else if (op == 16 || op == 17) begin
            if (s == 3) begin e[GB]=1; e[ROUT]=1; e[ZLOIN]=1; ctl = alu_of(op); end
            if (s == 4) begin e[ZLOOUT]=1; e[GA]=1; e[RIN]=1; end
        end else if (op == 14 || op == 15) begin
            if (s == 3) begin e[GA]=1; e[ROUT]=1; e[YIN]=1; end
            if (s == 4) begin e[GB]=1; e[ROUT]=1; e[ZLOIN]=1; e[ZHIIN]=1; ctl = alu_of(op); end
            if (s == 5) begin e[ZLOOUT]=1; e[LOIN]=1; end
            if (s == 6) begin e[ZHIOUT]=1; e[HIIN]=1; end
        end else if (op <= 2) begin
            if (s == 3) begin e[GB]=1; e[BAOUT]=1; e[YIN]=1; end
            if (s == 4) begin e[COUT]=1; e[ZLOIN]=1; end
            if (s == 5) begin
                e[ZLOOUT]=1;
                if (op == 1) begin e[GA]=1; e[RIN]=1; end else e[MARIN]=1;
            end
            if (s == 6 && op == 0) begin e[RD]=1; e[MDRIN]=1; mdr = 1; end
            if (s == 6 && op == 2) begin e[GA]=1; e[ROUT]=1; e[MDRIN]=1; end
            if (s == 7 && op == 0) begin e[MDROUT]=1; e[GA]=1; e[RIN]=1; end
            if (s == 7 && op == 2) e[WR]=1;
        end else if (op == 18) begin
            if (s == 3) begin e[GA]=1; e[ROUT]=1; e[CONIN]=1; end
            if (s == 4) begin e[PCOUT]=1; e[YIN]=1; end
            if (s == 5) begin e[COUT]=1; e[ZLOIN]=1; end
            if (s == 6) begin e[ZLOOUT]=1; e[PCIN]=con; end
        end else if (op == 19) begin
            e[GA]=1; e[ROUT]=1; e[PCIN]=1;
        end else if (op == 20) begin
            if (s == 3) begin e[PCOUT]=1; e[GB]=1; e[RIN]=1; end
            if (s == 4) begin e[GA]=1; e[ROUT]=1; e[PCIN]=1; end
        end else if (op == 21) begin e[INPOUT]=1; e[GA]=1; e[RIN]=1; end
        else if (op == 22) begin e[GA]=1; e[ROUT]=1; e[OUTPIN]=1; end
        else if (op == 23) begin e[HIOUT]=1; e[GA]=1; e[RIN]=1; end
        else if (op == 24) begin e[LOOUT]=1; e[GA]=1; e[RIN]=1; end
        e[33:30] = 4'(ctl);
        e[29:28] = 2'(mdr);
        return e;
    endfunction

    // One falling edge: advance the model, then compare at the following rising edge.
    task automatic tick(input string tag);
        @(negedge clk);
        if (reset)                        ms = M_RST;
        else if (ms == M_RST)             ms = 0;
        else if (ms == M_HALT)            ms = M_HALT;
        else if (ms == ilen(cur_op) - 1)  ms = (stop || cur_op == 26) ? M_HALT : 0;
        else                              ms = ms + 1;
        @(posedge clk); #1;
        chk($sformatf("%s_op%0d_s%0d", tag, cur_op, ms), dutv, expv(ms, cur_op, CON_FF));
    endtask

    // Run one instruction from T0 (or RESET) until the next boundary.
    task automatic run_op(input int op, input bit con, input int stop_step,
                          input int rst_step, output int cyc);
        logic [31:0] r;
        logic [4:0]  op5;
        r = $urandom();
        op5 = 5'(op);
        cur_op = op;
        IR = {op5, r[26:0]};
        CON_FF = con;
        stop = 1'b0;
        cyc = 0;
        if (ms == M_RST) tick("pre");
        do begin
            stop  = (stop_step >= 0 && ms >= stop_step && ms < M_RST);
            reset = (ms == rst_step);
            tick("ex");
            cyc++;
        end while (ms >= 1 && ms <= 7 && cyc < 20);
        reset = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset = 1'b1; stop = 1'b0; CON_FF = 1'b0; IR = '0;
        tick("rst"); tick("rst");
        reset = 1'b0;
        tick("rel");

        run_op(3, 0, -1, -1, c);   chk("add_len", 36'(c), 36'd6);
        run_op(0, 0, -1, -1, c);   chk("ld_len",  36'(c), 36'd8);
        run_op(18, 0, -1, -1, c);  chk("br0_len", 36'(c), 36'd7);
        run_op(18, 1, -1, -1, c);  chk("br1_len", 36'(c), 36'd7);
        run_op(14, 0, -1, -1, c);  chk("mul_len", 36'(c), 36'd7);
        run_op(2, 0, -1, -1, c);   chk("st_len",  36'(c), 36'd8);

        // stop raised during T4 of add: instruction completes, then HALT
        run_op(3, 0, 4, -1, c);    chk("stop_len", 36'(c), 36'd6);
        repeat (10) tick("halt");
        reset = 1'b1; tick("hrst"); reset = 1'b0; tick("hrel");

        run_op(26, 0, -1, -1, c);  chk("halt_len", 36'(c), 36'd3);
        repeat (3) tick("halt");
        reset = 1'b1; tick("hrst"); reset = 1'b0; tick("hrel");

        // reset in T3 of ld abandons the instruction
        run_op(0, 0, -1, 3, c);    chk("ldrst_len", 36'(c), 36'd4);
        tick("rel");

        repeat (200) begin
            int op, ss, rs;
            op = $urandom_range(0, 31);
            ss = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : -1;
            rs = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 7) : -1;
            run_op(op, 1'($urandom_range(0, 1)), ss, rs, c);
            if (ms == M_HALT) begin
                repeat ($urandom_range(1, 4)) tick("rhalt");
                reset = 1'b1; tick("rrst"); reset = 1'b0;
            end
            if (ms == M_RST) tick("rrel");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
